// File: rtl/midi_pkg.sv
// Shared MIDI constants: message-type codes, status nibbles and parser FSM states.
package midi_pkg;

   typedef enum logic [2:0] {
      MT_NOTE_OFF = 3'd0,
      MT_NOTE_ON  = 3'd1,
      MT_POLY_AT  = 3'd2,
      MT_CC       = 3'd3,
      MT_PROG     = 3'd4,
      MT_CHAN_AT  = 3'd5,
      MT_PITCH    = 3'd6
   } msg_type_e;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_POLY_AT  = 4'hA;
   localparam logic [3:0] ST_CC       = 4'hB;
   localparam logic [3:0] ST_PROG     = 4'hC;
   localparam logic [3:0] ST_CHAN_AT  = 4'hD;
   localparam logic [3:0] ST_PITCH    = 4'hE;
   localparam logic [7:0] ST_SYS_COMMON = 8'hF0;
   localparam logic [7:0] ST_REALTIME   = 8'hF8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_EMIT = 2'd2
   } state_e;

   function automatic logic [2:0] chan_type(input logic [3:0] nib);
      logic [2:0] t;
      case (nib)
         ST_NOTE_OFF: t = MT_NOTE_OFF;
         ST_NOTE_ON:  t = MT_NOTE_ON;
         ST_POLY_AT:  t = MT_POLY_AT;
         ST_CC:       t = MT_CC;
         ST_PROG:     t = MT_PROG;
         ST_CHAN_AT:  t = MT_CHAN_AT;
         ST_PITCH:    t = MT_PITCH;
         default:     t = MT_NOTE_OFF;
      endcase
      return t;
   endfunction

   // Program change and channel aftertouch carry one data byte; the rest carry two.
   function automatic logic need_two(input logic [2:0] t);
      return !((t == MT_PROG) || (t == MT_CHAN_AT));
   endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte FIFO read port and decoded-message handshake of the MIDI parser.
interface midi_msg_parser_if;
   logic [7:0] byte_in;
   logic       byte_vld;
   logic       byte_rd;
   logic       msg_valid;
   logic       msg_ready;
   logic [2:0] msg_type;
   logic [3:0] msg_chan;
   logic [6:0] msg_d1;
   logic [6:0] msg_d2;
   logic       err;

   modport slave (
      input  byte_in, byte_vld, msg_ready,
      output byte_rd, msg_valid, msg_type, msg_chan, msg_d1, msg_d2, err
   );

   modport master (
      output byte_in, byte_vld, msg_ready,
      input  byte_rd, msg_valid, msg_type, msg_chan, msg_d1, msg_d2, err
   );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser: pops bytes from a FWFT FIFO, tracks running status,
// and presents complete channel messages on a valid/ready handshake.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter bit         OMNI    = 1'b1,
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic             clk,
   input  logic             rst,
   midi_msg_parser_if.slave bus
);

   state_e     state_q, state_d;
   logic       rs_vld_q, rs_vld_d;
   logic [2:0] rs_type_q, rs_type_d;
   logic [3:0] rs_chan_q, rs_chan_d;
   logic       idx_q, idx_d;
   logic       sysex_q, sysex_d;
   logic [6:0] d1buf_q, d1buf_d;
   logic       done, emit, err_d;
   logic [2:0] type_d;
   logic [6:0] d1_d, d2_d;

   // Gated by rst so nothing leaves the FIFO during the reset cycle.
   assign bus.byte_rd = (state_q == S_POP) && !rst;

   always_comb begin
      state_d   = state_q;
      rs_vld_d  = rs_vld_q;
      rs_type_d = rs_type_q;
      rs_chan_d = rs_chan_q;
      idx_d     = idx_q;
      sysex_d   = sysex_q;
      d1buf_d   = d1buf_q;
      done      = 1'b0;
      emit      = 1'b0;
      err_d     = 1'b0;
      type_d    = rs_type_q;
      d1_d      = 7'd0;
      d2_d      = 7'd0;
      case (state_q)
         S_IDLE: if (bus.byte_vld && !bus.msg_valid) state_d = S_POP;
         S_POP: begin
            state_d = S_IDLE;
            if (bus.byte_in >= ST_REALTIME) begin
               // real-time bytes pass through without touching parser state
            end else if (bus.byte_in >= ST_SYS_COMMON) begin
               rs_vld_d = 1'b0;
               sysex_d  = 1'b1;
               idx_d    = 1'b0;
            end else if (bus.byte_in[7]) begin
               err_d     = idx_q;
               rs_vld_d  = 1'b1;
               rs_type_d = chan_type(bus.byte_in[7:4]);
               rs_chan_d = bus.byte_in[3:0];
               idx_d     = 1'b0;
               sysex_d   = 1'b0;
            end else if (!rs_vld_q) begin
               err_d = !sysex_q;
            end else if (!idx_q && need_two(rs_type_q)) begin
               d1buf_d = bus.byte_in[6:0];
               idx_d   = 1'b1;
            end else begin
               done  = 1'b1;
               idx_d = 1'b0;
               d1_d  = idx_q ? d1buf_q : bus.byte_in[6:0];
               d2_d  = idx_q ? bus.byte_in[6:0] : 7'd0;
               if ((rs_type_q == MT_NOTE_ON) && (d2_d == 7'd0)) type_d = MT_NOTE_OFF;
            end
            emit = done && (OMNI || (rs_chan_q == CHANNEL));
            if (emit) state_d = S_EMIT;
         end
         S_EMIT: if (bus.msg_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rs_vld_q <= 1'b0;
         idx_q    <= 1'b0;
         sysex_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rs_vld_q <= rs_vld_d;
         idx_q    <= idx_d;
         sysex_q  <= sysex_d;
      end
   end

   always_ff @(posedge clk) begin
      rs_type_q <= rs_type_d;
      rs_chan_q <= rs_chan_d;
      d1buf_q   <= d1buf_d;
   end

   // Message outputs load only on emit and then hold until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.msg_valid <= 1'b0;
         bus.msg_type  <= 3'd0;
         bus.msg_chan  <= 4'd0;
         bus.msg_d1    <= 7'd0;
         bus.msg_d2    <= 7'd0;
         bus.err       <= 1'b0;
      end else begin
         bus.err <= err_d;
         if (emit) begin
            bus.msg_valid <= 1'b1;
            bus.msg_type  <= type_d;
            bus.msg_chan  <= rs_chan_q;
            bus.msg_d1    <= d1_d;
            bus.msg_d2    <= d2_d;
         end else if ((state_q == S_EMIT) && bus.msg_ready) begin
            bus.msg_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed vector table, corner sequences,
// and a random byte stream checked against a queue-based MIDI reference model.
module tb_midi_msg_parser;
   import midi_pkg::*;

   typedef struct packed {
      logic [2:0] t;
      logic [3:0] c;
      logic [6:0] d1;
      logic [6:0] d2;
   } msg_t;

   typedef struct {
      logic [47:0] b;
      int          n;
      int          nmsg;
      int          nerr;
      msg_t        m0;
      msg_t        m1;
   } vec_t;

   logic clk;
   logic rst;

   midi_msg_parser_if u_bus ();
   midi_msg_parser_if f_bus ();

   midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_dut (.clk(clk), .rst(rst), .bus(u_bus));
   midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd5)) f_dut (.clk(clk), .rst(rst), .bus(f_bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t       vecs[10];
   logic [7:0] qu[$], qf[$];
   msg_t       recv_u[$], recv_f[$], exp_q[$];
   bit         pend_u, pend_f, last_u, last_f, hold_u, rand_ready;
   logic       ready_u;
   msg_t       held_u;
   int         pops_u, pops_f, errs_u, errs_f, viol, stab, total, bad;

   // reference model state
   bit         m_rs_ok, m_sysex;
   logic [2:0] m_type;
   logic [3:0] m_chan;
   logic [6:0] m_data[$];
   int         exp_err;

   function automatic msg_t mk(input logic [2:0] t, input logic [3:0] c,
                               input logic [6:0] d1, input logic [6:0] d2);
      return {t, c, d1, d2};
   endfunction

   function automatic msg_t out_u();
      return {u_bus.msg_type, u_bus.msg_chan, u_bus.msg_d1, u_bus.msg_d2};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      int   need;
      msg_t m;
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_rs_ok = 1'b0; m_sysex = 1'b1; m_data.delete();
         return;
      end
      if (b[7]) begin
         if (m_data.size() > 0) exp_err++;
         m_rs_ok = 1'b1; m_sysex = 1'b0; m_data.delete();
         m_type = 3'(b[6:4]); m_chan = b[3:0];
         return;
      end
      if (!m_rs_ok) begin
         if (!m_sysex) exp_err++;
         return;
      end
      m_data.push_back(b[6:0]);
      need = (m_type == 3'd4 || m_type == 3'd5) ? 1 : 2;
      if (m_data.size() == need) begin
         m.c  = m_chan;
         m.d1 = m_data[0];
         m.d2 = (need == 2) ? m_data[1] : 7'd0;
         m.t  = (m_type == 3'd1 && m.d2 == 7'd0) ? 3'd0 : m_type;
         exp_q.push_back(m);
         m_data.delete();
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (pend_u) void'(qu.pop_front());
      if (pend_f) void'(qf.pop_front());
      u_bus.byte_vld  = (qu.size() != 0);
      u_bus.byte_in   = (qu.size() != 0) ? qu[0] : 8'h00;
      f_bus.byte_vld  = (qf.size() != 0);
      f_bus.byte_in   = (qf.size() != 0) ? qf[0] : 8'h00;
      u_bus.msg_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_u;
      f_bus.msg_ready = 1'b1;
      pend_u = u_bus.byte_rd;
      pend_f = f_bus.byte_rd;
      if (pend_u) pops_u++;
      if (pend_f) pops_f++;
      if ((pend_u && (last_u || u_bus.msg_valid)) || (pend_f && (last_f || f_bus.msg_valid))) viol++;
      if (rst && (pend_u || pend_f)) viol++;
      last_u = pend_u;
      last_f = pend_f;
      if (!rst && hold_u && (!u_bus.msg_valid || out_u() != held_u)) stab++;
      hold_u = u_bus.msg_valid && !u_bus.msg_ready;
      held_u = out_u();
      if (u_bus.msg_valid && u_bus.msg_ready) recv_u.push_back(out_u());
      if (f_bus.msg_valid && f_bus.msg_ready)
         recv_f.push_back({f_bus.msg_type, f_bus.msg_chan, f_bus.msg_d1, f_bus.msg_d2});
      if (u_bus.err) errs_u++;
      if (f_bus.err) errs_f++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      qu.delete(); qf.delete(); recv_u.delete(); recv_f.delete();
      pend_u = 1'b0; pend_f = 1'b0; hold_u = 1'b0;
      u_bus.byte_vld = 1'b0; f_bus.byte_vld = 1'b0;
      pops_u = 0; pops_f = 0; errs_u = 0; errs_f = 0;
      m_rs_ok = 1'b0; m_sysex = 1'b0; m_data.delete(); exp_q.delete(); exp_err = 0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_u"}, 32'({u_bus.byte_rd, u_bus.msg_valid, u_bus.msg_type, u_bus.msg_chan,
                               u_bus.msg_d1, u_bus.msg_d2, u_bus.err}), 32'd0);
      check({name, "_f"}, 32'({f_bus.byte_rd, f_bus.msg_valid, f_bus.msg_type, f_bus.msg_chan,
                               f_bus.msg_d1, f_bus.msg_d2, f_bus.err}), 32'd0);
   endtask

   task automatic drain(input int budget);
      int idle = 0;
      int cyc  = 0;
      while (idle < 3 && cyc < budget) begin
         step();
         cyc++;
         if (qu.size() == 0 && qf.size() == 0 && !pend_u && !pend_f &&
             !u_bus.msg_valid && !f_bus.msg_valid) idle++;
         else idle = 0;
      end
      check("drain_idle", 32'(idle >= 3), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int cyc = 0;
      while (!u_bus.msg_valid && cyc < budget) begin
         step();
         cyc++;
      end
      check("wait_valid", 32'(u_bus.msg_valid), 32'd1);
   endtask

   task automatic push_u(input logic [47:0] bytes, input int n);
      for (int k = 0; k < n; k++) qu.push_back(bytes[47 - 8*k -: 8]);
   endtask

   task automatic push_f(input logic [47:0] bytes, input int n);
      for (int k = 0; k < n; k++) qf.push_back(bytes[47 - 8*k -: 8]);
   endtask

   task automatic set_vec(input int i, input logic [47:0] b, input int n, input int nmsg,
                          input int nerr, input msg_t m0, input msg_t m1);
      vecs[i].b = b; vecs[i].n = n; vecs[i].nmsg = nmsg; vecs[i].nerr = nerr;
      vecs[i].m0 = m0; vecs[i].m1 = m1;
   endtask

   initial begin
      msg_t       snap, got;
      int         pops_snap;
      logic [7:0] b;
      int         r;
      rst = 1'b1; ready_u = 1'b1; rand_ready = 1'b0;
      total = 0; bad = 0; viol = 0; stab = 0; last_u = 0; last_f = 0;
      pend_u = 0; pend_f = 0; hold_u = 0;
      u_bus.byte_vld = 1'b0; u_bus.byte_in = 8'h00; u_bus.msg_ready = 1'b1;
      f_bus.byte_vld = 1'b0; f_bus.byte_in = 8'h00; f_bus.msg_ready = 1'b1;

      do_reset();
      check_reset_outputs("reset_state");

      set_vec(0, 48'h933C64000000, 3, 1, 0, mk(3'd1, 4'd3, 7'h3C, 7'h64), '0);
      set_vec(1, 48'h90407F400000, 5, 2, 0, mk(3'd1, 4'd0, 7'h40, 7'h7F), mk(3'd0, 4'd0, 7'h40, 7'h00));
      set_vec(2, 48'hB0F807FE5000, 5, 1, 0, mk(3'd3, 4'd0, 7'h07, 7'h50), '0);
      set_vec(3, 48'h450000000000, 1, 0, 1, '0, '0);
      set_vec(4, 48'h903CC2050000, 4, 1, 1, mk(3'd4, 4'd2, 7'h05, 7'h00), '0);
      set_vec(5, 48'hF07E01F71200, 5, 0, 0, '0, '0);
      set_vec(6, 48'hE10040000000, 3, 1, 0, mk(3'd6, 4'd1, 7'h00, 7'h40), '0);
      set_vec(7, 48'hD73300000000, 2, 1, 0, mk(3'd5, 4'd7, 7'h33, 7'h00), '0);
      set_vec(8, 48'h953C00A21020, 6, 2, 0, mk(3'd0, 4'd5, 7'h3C, 7'h00), mk(3'd2, 4'd2, 7'h10, 7'h20));
      set_vec(9, 48'hF810C3000000, 3, 0, 1, '0, '0);

      for (int i = 0; i < 10; i++) begin
         do_reset();
         ready_u = 1'b1;
         push_u(vecs[i].b, vecs[i].n);
         drain(200);
         check($sformatf("v%0d_nmsg", i), 32'(recv_u.size()), 32'(vecs[i].nmsg));
         check($sformatf("v%0d_err", i), 32'(errs_u), 32'(vecs[i].nerr));
         check($sformatf("v%0d_pops", i), 32'(pops_u), 32'(vecs[i].n));
         if (vecs[i].nmsg > 0) begin
            got = (recv_u.size() > 0) ? recv_u[0] : '0;
            check($sformatf("v%0d_msg0", i), 32'(got), 32'(vecs[i].m0));
         end
         if (vecs[i].nmsg > 1) begin
            got = (recv_u.size() > 1) ? recv_u[1] : '0;
            check($sformatf("v%0d_msg1", i), 32'(got), 32'(vecs[i].m1));
         end
      end

      // backpressure: message held, FIFO not popped while stalled
      do_reset();
      ready_u = 1'b0;
      push_u(48'h933C64933D65, 6);
      wait_valid(50);
      snap = out_u();
      pops_snap = pops_u;
      check("bp_first", 32'(snap), 32'(mk(3'd1, 4'd3, 7'h3C, 7'h64)));
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("bp_hold%0d", k),
               32'({u_bus.msg_valid, out_u(), 8'(pops_u - pops_snap)}), 32'({1'b1, snap, 8'd0}));
      end
      ready_u = 1'b1;
      drain(100);
      check("bp_nmsg", 32'(recv_u.size()), 32'd2);
      got = (recv_u.size() > 1) ? recv_u[1] : '0;
      check("bp_second", 32'(got), 32'(mk(3'd1, 4'd3, 7'h3D, 7'h65)));
      check("bp_pops", 32'(pops_u), 32'd6);

      // reset while a message is pending drops it
      do_reset();
      ready_u = 1'b0;
      push_u(48'h903C64000000, 3);
      wait_valid(50);
      do_reset();
      check_reset_outputs("rst_emit");
      ready_u = 1'b1;
      repeat (5) step();
      check("rst_emit_nomsg", 32'(recv_u.size()), 32'd0);

      // reset mid-message: partial dropped, following data byte is an error
      do_reset();
      push_u(48'h953C00000000, 2);
      drain(50);
      do_reset();
      check_reset_outputs("rst_mid");
      push_u(48'h400000000000, 1);
      drain(50);
      check("rst_mid_err", 32'(errs_u), 32'd1);
      check("rst_mid_nomsg", 32'(recv_u.size()), 32'd0);

      // channel filter on the OMNI=0, CHANNEL=5 instance
      do_reset();
      push_f(48'h943C40000000, 3);
      drain(50);
      check("flt_drop_nmsg", 32'(recv_f.size()), 32'd0);
      check("flt_drop_err", 32'(errs_f), 32'd0);
      check("flt_drop_pops", 32'(pops_f), 32'd3);
      push_f(48'h953C40000000, 3);
      drain(50);
      check("flt_pass_nmsg", 32'(recv_f.size()), 32'd1);
      got = (recv_f.size() > 0) ? recv_f[0] : '0;
      check("flt_pass_msg", 32'(got), 32'(mk(3'd1, 4'd5, 7'h3C, 7'h40)));

      // random byte stream with random backpressure against the reference model
      do_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 25)      b = 8'h80 + 8'($urandom_range(0, 111));
         else if (r < 30) b = 8'hF0 + 8'($urandom_range(0, 7));
         else if (r < 38) b = 8'hF8 + 8'($urandom_range(0, 7));
         else             b = 8'($urandom_range(0, 127));
         qu.push_back(b);
         model_byte(b);
      end
      drain(8000);
      rand_ready = 1'b0;
      check("rnd_nmsg", 32'(recv_u.size()), 32'(exp_q.size()));
      check("rnd_err", 32'(errs_u), 32'(exp_err));
      check("rnd_pops", 32'(pops_u), 32'd400);
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < recv_u.size()) ? recv_u[i] : '0;
         check($sformatf("rnd_msg%0d", i), 32'(got), 32'(exp_q[i]));
      end

      check("rd_protocol", 32'(viol), 32'd0);
      check("out_stable", 32'(stab), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/midi_msg_parser.md
MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 The block SHALL have parameter OMNI, default 1: 1 = accept all channels, 0 = accept only CHANNEL.
REQ-002 The block SHALL have parameter CHANNEL, default 0: 4-bit MIDI channel used when OMNI=0.
REQ-003 The block SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 The block SHALL have port byte_in  in  8: head-of-FIFO byte, valid whenever byte_vld=1 (first-word-fall-through).
REQ-006 The block SHALL have port byte_vld  in  1: FIFO non-empty.
REQ-007 The block SHALL have port byte_rd  out  1: one-cycle pop strobe; byte_in is sampled in the same cycle.
REQ-008 The block SHALL have port msg_valid  out  1: a decoded message is presented.
REQ-009 The block SHALL have port msg_ready  in  1: consumer accepts the message.
REQ-010 The block SHALL have port msg_type  out  3: 0 note_off, 1 note_on, 2 poly_at, 3 cc, 4 prog, 5 chan_at, 6 pitch.
REQ-011 The block SHALL have port msg_chan  out  4: MIDI channel of the message.
REQ-012 The block SHALL have port msg_d1  out  7: first data byte, or 0 if absent.
REQ-013 The block SHALL have port msg_d2  out  7: second data byte, or 0 if absent.
REQ-014 The block SHALL have port err  out  1: one-cycle pulse on every protocol error.

Function
REQ-015 The FSM SHALL have states S_IDLE, S_POP and S_EMIT.
- S_IDLE -> S_POP when byte_vld=1 and msg_valid=0.
- S_POP: byte_rd=1 for exactly one cycle; the byte is decoded; the next state is S_EMIT if the message is complete, else S_IDLE.
- S_EMIT -> S_IDLE on msg_valid & msg_ready.
REQ-016 byte_rd SHALL never be asserted on two consecutive cycles, nor while msg_valid=1.
REQ-017 Channel status 0x80-0xEF SHALL load running status (type = bits[6:4], chan = bits[3:0]) and clear the data index.
REQ-018 Expected data count SHALL be 1 for prog/chan_at and 2 for all other channel types.
REQ-019 A data byte (bit7=0) with valid running status SHALL be stored at the current data index; when the count is reached the message SHALL complete and the index SHALL reset to 0, running status retained.
REQ-020 msg_valid SHALL rise the cycle after the S_POP cycle that completes a message; all msg_* outputs SHALL hold stable until accepted.
REQ-021 note_on with d2=0 SHALL be emitted as msg_type=0 (note_off), d2=0.
REQ-022 pitch SHALL present the LSB on d1 and the MSB on d2, unmodified.
REQ-023 Real-time bytes 0xF8-0xFF SHALL be consumed and ignored without altering running status or the data index.
REQ-024 System common/SysEx bytes 0xF0-0xF7 SHALL clear running status; data bytes following them SHALL be discarded silently until the next channel status.
REQ-025 A data byte with no running status, outside SysEx, SHALL be discarded and pulse err.
REQ-026 A channel status arriving with a partially received message SHALL abandon the partial message, pulse err, and start the new one.
REQ-027 When OMNI=0, completed messages with chan != CHANNEL SHALL be discarded (no msg_valid, no err).
REQ-028 Throughput SHALL be at most one pop per 2 cycles; msg_valid held low by msg_ready SHALL stall popping (backpressure to the FIFO).

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL set: state=S_IDLE, byte_rd=0, msg_valid=0, msg_type=0, msg_chan=0, msg_d1=0, msg_d2=0, err=0, running status invalid, data index=0, SysEx flag=0.
REQ-030 Reset mid-message or mid-emit SHALL drop the partial or pending message; no byte SHALL be popped in the reset cycle.

Structure
REQ-031 Message-type codes, status-nibble constants (0x8-0xE, 0xF0, 0xF8) and FSM state encodings SHALL live in the shared synth package midi_pkg.
REQ-032 The block SHALL be one module with no sub-modules; its parent SHALL connect byte_in/byte_vld/byte_rd to the uart_fifo word_out/word_rdy/word_out_valid.

Verification
REQ-033 Stream 0x93 0x3C 0x64 -> one message: type=1, chan=3, d1=0x3C, d2=0x64; byte_rd pulses 3 times, never back-to-back.
REQ-034 Running status 0x90 0x40 0x7F 0x40 0x00 -> note_on(0x40,0x7F), then note_off(0x40,0); err never asserted.
REQ-035 Interleaved real-time 0xB0 0xF8 0x07 0xFE 0x50 -> single cc chan 0, d1=0x07, d2=0x50.
REQ-036 Errors: 0x45 after reset -> err pulse, no msg; 0x90 0x3C 0xC2 0x05 -> err pulse, then prog chan 2, d1=0x05, d2=0.
REQ-037 Backpressure: msg_ready=0 for 10 cycles with 6 bytes queued -> outputs stable, no byte_rd until accept; SysEx 0xF0 0x7E 0x01 0xF7 0x12 -> no msg, no err.
REQ-038 Filter/reset: OMNI=0, CHANNEL=5, stream 0x94 0x3C 0x40 -> no msg; rst asserted after 0x95 0x3C -> all outputs 0, and a following 0x40 pulses err.
